// File: rtl/sent_rx_serial_decode.sv
// SENT RX slow-channel decoder: rebuilds short / enhanced serial messages
// from status bits 3:2 of accepted fast frames and strobes them out.
//
// Ports:
//   clk_rx, reset_rx       receiver clock, sync active-high reset
//   frame_valid            one pulse per good fast frame
//   status_bits[1:0]       {status bit3, status bit2} of that frame
//   frame_error            fast-frame error pulse (wins over frame_valid)
//   id_decode[7:0]         decoded message ID (held until next accept)
//   data_decode[15:0]      decoded message data (held until next accept)
//   config_bit_decode      enhanced C bit, 0 for short messages
//   valid_data_serial      1-cycle strobe, short message accepted
//   valid_data_enhanced    1-cycle strobe, enhanced message accepted
//   serial_crc_error       1-cycle strobe, complete message failed CRC
//
// Build option: SENT_SERIAL_CRC_EN enables the CRC4/CRC6 message check
// (and the CRC4_SEED / CRC6_SEED parameters); without it every
// structurally complete message is accepted.
module sent_rx_serial_decode
`ifdef SENT_SERIAL_CRC_EN
  #(
    parameter logic [3:0] CRC4_SEED = 4'b0101,
    parameter logic [5:0] CRC6_SEED = 6'b010101
  )
`endif
  (
  input  logic        clk_rx,
  input  logic        reset_rx,
  input  logic        frame_valid,
  input  logic [1:0]  status_bits,
  input  logic        frame_error,
  output logic [7:0]  id_decode,
  output logic [15:0] data_decode,
  output logic        config_bit_decode,
  output logic        valid_data_serial,
  output logic        valid_data_enhanced,
  output logic        serial_crc_error
);

  typedef enum logic [1:0] {IDLE, ONES, SHORT, ENH} state_t;

  state_t      state_q, state_d;
  logic [2:0]  ones_q, ones_d;
  logic [4:0]  fcnt_q, fcnt_d;
  logic [17:0] b3_sr_q, b3_sr_d;
  logic [17:0] b2_sr_q, b2_sr_d;
  logic [7:0]  id_q, id_d;
  logic [15:0] data_q, data_d;
  logic        cfg_q, cfg_d;
  logic        vs_q, vs_d;
  logic        ve_q, ve_d;
  logic        err_q, err_d;

  logic        s3, s2;
  logic [17:0] win3, win2;
  logic [4:0]  nxt;
  logic        short_ok, enh_ok;
  logic        c_bit;
  logic [3:0]  a_nib, b_nib;
  logic [11:0] d12;

  assign s3  = status_bits[1];
  assign s2  = status_bits[0];
  // Frame window including the frame arriving this cycle; frame k of an
  // 18-frame message sits at bit 18-k, of a 16-frame message at 16-k.
  assign win3 = {b3_sr_q[16:0], s3};
  assign win2 = {b2_sr_q[16:0], s2};
  assign nxt  = fcnt_q + 5'd1;

  assign c_bit = win3[10];
  assign a_nib = win3[9:6];
  assign b_nib = win3[4:1];
  assign d12   = win2[11:0];

`ifdef SENT_SERIAL_CRC_EN
  function automatic logic [3:0] crc4(input logic [11:0] d);
    logic [15:0] m;
    logic [3:0]  c;
    m = {d, 4'h0};
    c = CRC4_SEED;
    for (int i = 15; i >= 0; i--)
      c = {c[2:0], m[i]} ^ (c[3] ? 4'b1101 : 4'b0000);
    return c;
  endfunction

  function automatic logic [5:0] crc6(input logic [23:0] d);
    logic [29:0] m;
    logic [5:0]  c;
    m = {d, 6'h00};
    c = CRC6_SEED;
    for (int i = 29; i >= 0; i--)
      c = {c[4:0], m[i]} ^ (c[5] ? 6'b011001 : 6'b000000);
    return c;
  endfunction

  // Enhanced CRC covers frames 7..18 as {bit2, bit3} pairs.
  logic [23:0] il;
  for (genvar j = 0; j < 12; j++) begin : g_il
    assign il[2*j+1 -: 2] = {win2[j], win3[j]};
  end

  assign short_ok = (crc4(win2[15:4]) == win2[3:0]);
  assign enh_ok   = (crc6(il) == win2[17:12]);
`else
  assign short_ok = 1'b1;
  assign enh_ok   = 1'b1;
`endif

  // Oldest register bits shift out unread; CRC bits unread without check.
  logic unused_ok;
  assign unused_ok = ^{b3_sr_q[17], b2_sr_q[17], win3, win2};

  always_comb begin
    state_d = state_q;
    ones_d  = ones_q;
    fcnt_d  = fcnt_q;
    b3_sr_d = b3_sr_q;
    b2_sr_d = b2_sr_q;
    id_d    = id_q;
    data_d  = data_q;
    cfg_d   = cfg_q;
    vs_d    = 1'b0;
    ve_d    = 1'b0;
    err_d   = 1'b0;
    if (frame_error) begin
      state_d = IDLE;
      ones_d  = 3'd0;
      fcnt_d  = 5'd0;
    end else if (frame_valid) begin
      b3_sr_d = win3;
      b2_sr_d = win2;
      unique case (state_q)
        IDLE: begin
          if (s3) begin
            state_d = ONES;
            ones_d  = 3'd1;
          end
        end
        ONES: begin
          if (s3) begin
            if (ones_q != 3'd6) ones_d = ones_q + 3'd1;
          end else begin
            ones_d = 3'd0;
            if (ones_q == 3'd1) begin
              state_d = SHORT;
              fcnt_d  = 5'd2;
            end else if (ones_q == 3'd6) begin
              state_d = ENH;
              fcnt_d  = 5'd7;
            end else begin
              state_d = IDLE;
            end
          end
        end
        SHORT: begin
          if (s3) begin
            state_d = ONES;
            ones_d  = 3'd1;
            fcnt_d  = 5'd0;
          end else if (nxt == 5'd16) begin
            state_d = IDLE;
            fcnt_d  = 5'd0;
            if (short_ok) begin
              id_d   = {4'h0, win2[15:12]};
              data_d = {8'h00, win2[11:4]};
              cfg_d  = 1'b0;
              vs_d   = 1'b1;
            end else begin
              err_d  = 1'b1;
            end
          end else begin
            fcnt_d = nxt;
          end
        end
        ENH: begin
          fcnt_d = nxt;
          // bit3 is a fixed 0 at frames 13 and 18: a 1 there is a new start.
          if (s3 && (nxt == 5'd13 || nxt == 5'd18)) begin
            state_d = ONES;
            ones_d  = 3'd1;
            fcnt_d  = 5'd0;
          end else if (nxt == 5'd18) begin
            state_d = IDLE;
            fcnt_d  = 5'd0;
            if (enh_ok) begin
              id_d   = c_bit ? {4'h0, a_nib} : {a_nib, b_nib};
              data_d = c_bit ? {b_nib, d12} : {4'h0, d12};
              cfg_d  = c_bit;
              ve_d   = 1'b1;
            end else begin
              err_d  = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_rx) begin
    if (reset_rx) begin
      state_q <= IDLE;
      ones_q  <= 3'd0;
      fcnt_q  <= 5'd0;
      b3_sr_q <= 18'd0;
      b2_sr_q <= 18'd0;
      id_q    <= 8'd0;
      data_q  <= 16'd0;
      cfg_q   <= 1'b0;
      vs_q    <= 1'b0;
      ve_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ones_q  <= ones_d;
      fcnt_q  <= fcnt_d;
      b3_sr_q <= b3_sr_d;
      b2_sr_q <= b2_sr_d;
      id_q    <= id_d;
      data_q  <= data_d;
      cfg_q   <= cfg_d;
      vs_q    <= vs_d;
      ve_q    <= ve_d;
      err_q   <= err_d;
    end
  end

  assign id_decode           = id_q;
  assign data_decode         = data_q;
  assign config_bit_decode   = cfg_q;
  assign valid_data_serial   = vs_q;
  assign valid_data_enhanced = ve_q;
  assign serial_crc_error    = err_q;

endmodule

// File: tb/tb_sent_rx_serial_decode.sv
// Bench for sent_rx_serial_decode: frame-level stimulus with a
// scoreboard of expected strobes and decoded outputs.
module tb_sent_rx_serial_decode;

  logic        clk_rx = 1'b0;
  logic        reset_rx;
  logic        frame_valid;
  logic [1:0]  status_bits;
  logic        frame_error;
  logic [7:0]  id_decode;
  logic [15:0] data_decode;
  logic        config_bit_decode;
  logic        valid_data_serial;
  logic        valid_data_enhanced;
  logic        serial_crc_error;

  sent_rx_serial_decode dut (
    .clk_rx              (clk_rx),
    .reset_rx            (reset_rx),
    .frame_valid         (frame_valid),
    .status_bits         (status_bits),
    .frame_error         (frame_error),
    .id_decode           (id_decode),
    .data_decode         (data_decode),
    .config_bit_decode   (config_bit_decode),
    .valid_data_serial   (valid_data_serial),
    .valid_data_enhanced (valid_data_enhanced),
    .serial_crc_error    (serial_crc_error)
  );

  always #5 clk_rx = ~clk_rx;

  // stb = {valid_data_serial, valid_data_enhanced, serial_crc_error}
  typedef struct {
    logic [2:0]  stb;
    logic [7:0]  id;
    logic [15:0] data;
    logic        cfg;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          n_checks = 0;
  int          n_fail   = 0;
  int          gap      = 1;
  logic        crc_on;
  logic [7:0]  m_id   = 8'h00;
  logic [15:0] m_data = 16'h0000;
  logic        m_cfg  = 1'b0;

  // Reference CRCs by polynomial long division of {seed, data, zeros}.
  function automatic logic [3:0] m_crc4(input logic [11:0] d);
    logic [19:0] r;
    r = {4'b0101, d, 4'h0};
    for (int i = 19; i >= 4; i--)
      if (r[i]) r[i -: 5] = r[i -: 5] ^ 5'b11101;
    return r[3:0];
  endfunction

  function automatic logic [5:0] m_crc6(input logic [23:0] d);
    logic [35:0] r;
    r = {6'b010101, d, 6'h00};
    for (int i = 35; i >= 6; i--)
      if (r[i]) r[i -: 7] = r[i -: 7] ^ 7'b1011001;
    return r[5:0];
  endfunction

  always @(negedge clk_rx) begin
    if (valid_data_serial || valid_data_enhanced || serial_crc_error) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_strobe: got %b, required none",
                 {valid_data_serial, valid_data_enhanced, serial_crc_error});
      end else begin
        mon_e = sb.pop_front();
        n_checks += 3;
        if ({valid_data_serial, valid_data_enhanced, serial_crc_error}
            !== mon_e.stb) begin
          n_fail++;
          $display("FAIL strobe: got %b, required %b",
                   {valid_data_serial, valid_data_enhanced, serial_crc_error},
                   mon_e.stb);
        end
        if (id_decode !== mon_e.id) begin
          n_fail++;
          $display("FAIL id_decode: got %h, required %h", id_decode, mon_e.id);
        end
        if ({data_decode, config_bit_decode} !== {mon_e.data, mon_e.cfg}) begin
          n_fail++;
          $display("FAIL data_cfg: got %h/%b, required %h/%b",
                   data_decode, config_bit_decode, mon_e.data, mon_e.cfg);
        end
      end
    end
  end

  task automatic send_frame(input logic s3, input logic s2);
    status_bits = {s3, s2};
    frame_valid = 1'b1;
    @(negedge clk_rx);
    frame_valid = 1'b0;
    status_bits = 2'b00;
    repeat (gap) @(negedge clk_rx);
  endtask

  task automatic send_short(input logic [3:0] id, input logic [7:0] data,
                            input logic flip);
    logic [3:0]  crc;
    logic [15:0] seq;
    exp_t        e;
    crc = m_crc4({id, data}) ^ {3'b000, flip};
    seq = {id, data, crc};
    if (flip && crc_on) begin
      e = '{3'b001, m_id, m_data, m_cfg};
    end else begin
      m_id   = {4'h0, id};
      m_data = {8'h00, data};
      m_cfg  = 1'b0;
      e = '{3'b100, m_id, m_data, m_cfg};
    end
    sb.push_back(e);
    for (int k = 1; k <= 16; k++) send_frame(k == 1, seq[16-k]);
  endtask

  task automatic send_enh(input logic c, input logic [3:0] a,
                          input logic [3:0] b, input logic [11:0] d12,
                          input int nfr, input logic ab13);
    logic        s3a [1:18];
    logic        s2a [1:18];
    logic [23:0] il;
    logic [5:0]  crc;
    exp_t        e;
    il = 24'h0;
    for (int k = 1; k <= 18; k++) begin
      s3a[k] = 1'b0;
      if (k <= 6) s3a[k] = 1'b1;
      if (k == 8) s3a[k] = c;
      if (k >= 9 && k <= 12) s3a[k] = a[12-k];
      if (k >= 14 && k <= 17) s3a[k] = b[17-k];
      s2a[k] = (k >= 7) ? d12[18-k] : 1'b0;
    end
    for (int k = 7; k <= 18; k++) il = {il[21:0], s2a[k], s3a[k]};
    crc = m_crc6(il);
    for (int k = 1; k <= 6; k++) s2a[k] = crc[6-k];
    if (ab13) s3a[13] = 1'b1;
    if (nfr == 18 && !ab13) begin
      m_id   = c ? {4'h0, a} : {a, b};
      m_data = c ? {b, d12} : {4'h0, d12};
      m_cfg  = c;
      e = '{3'b010, m_id, m_data, m_cfg};
      sb.push_back(e);
    end
    for (int k = 1; k <= nfr; k++) send_frame(s3a[k], s2a[k]);
  endtask

  task automatic test_reset;
    reset_rx    = 1'b1;
    frame_valid = 1'b0;
    frame_error = 1'b0;
    status_bits = 2'b00;
    repeat (3) @(posedge clk_rx);
    #1;
    n_checks += 3;
    if (id_decode !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_id: got %h, required 00", id_decode);
    end
    if (data_decode !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_data: got %h, required 0000", data_decode);
    end
    if ({config_bit_decode, valid_data_serial, valid_data_enhanced,
         serial_crc_error} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b, required 0000",
               {config_bit_decode, valid_data_serial, valid_data_enhanced,
                serial_crc_error});
    end
    @(negedge clk_rx);
    reset_rx = 1'b0;
    @(negedge clk_rx);
  endtask

  task automatic test_short;
    send_short(4'h3, 8'h01, 1'b0);
    send_short(4'hC, 8'hA5, 1'b0);
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk_rx);
    repeat (3) @(negedge clk_rx);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL short_drain: got %0d pending, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_enhanced;
    send_enh(1'b0, 4'h5, 4'hA, 12'h123, 18, 1'b0);
    send_enh(1'b1, 4'h7, 4'hC, 12'hABC, 18, 1'b0);
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk_rx);
    repeat (3) @(negedge clk_rx);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL enh_drain: got %0d pending, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_crc_error;
    send_short(4'h3, 8'h01, 1'b0);
    send_short(4'h9, 8'h44, 1'b1);
    send_enh(1'b1, 4'h2, 4'h6, 12'h5F0, 18, 1'b0);
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk_rx);
    repeat (3) @(negedge clk_rx);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL crc_drain: got %0d pending, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_frame_error;
    send_enh(1'b0, 4'h5, 4'hA, 12'h123, 9, 1'b0);
    frame_error = 1'b1;
    send_frame(1'b1, 1'b1);
    frame_error = 1'b0;
    send_short(4'hE, 8'hB7, 1'b0);
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk_rx);
    repeat (3) @(negedge clk_rx);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL ferr_drain: got %0d pending, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_restart;
    // 3 ones then 0 is no valid preamble; later zeros stay idle.
    send_frame(1'b1, 1'b0);
    send_frame(1'b1, 1'b1);
    send_frame(1'b1, 1'b0);
    send_frame(1'b0, 1'b1);
    send_frame(1'b0, 1'b1);
    send_short(4'h5, 8'h5A, 1'b0);
    // A 1 at frame 13 restarts; the run of 7 ones saturates to enhanced.
    send_enh(1'b0, 4'h3, 4'h9, 12'hFFF, 13, 1'b1);
    send_enh(1'b0, 4'hD, 4'h1, 12'h804, 18, 1'b0);
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk_rx);
    repeat (3) @(negedge clk_rx);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL restart_drain: got %0d pending, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_back_to_back;
    gap = 0;
    send_short(4'h1, 8'h80, 1'b0);
    send_short(4'h2, 8'h7F, 1'b0);
    send_enh(1'b1, 4'hF, 4'h0, 12'h001, 18, 1'b0);
    send_enh(1'b0, 4'h6, 4'hE, 12'hC3C, 18, 1'b0);
    gap = 1;
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk_rx);
    repeat (3) @(negedge clk_rx);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL b2b_drain: got %0d pending, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_mid_reset;
    send_short(4'h3, 8'h01, 1'b0);
    repeat (3) @(negedge clk_rx);
    send_frame(1'b1, 1'b0);
    send_frame(1'b0, 1'b1);
    send_frame(1'b0, 1'b1);
    reset_rx = 1'b1;
    @(posedge clk_rx);
    #1;
    n_checks += 2;
    if ({id_decode, data_decode} !== 24'h000000) begin
      n_fail++;
      $display("FAIL midreset_data: got %h/%h, required 00/0000",
               id_decode, data_decode);
    end
    if ({config_bit_decode, valid_data_serial, valid_data_enhanced,
         serial_crc_error} !== 4'b0000) begin
      n_fail++;
      $display("FAIL midreset_flags: got %b, required 0000",
               {config_bit_decode, valid_data_serial, valid_data_enhanced,
                serial_crc_error});
    end
    @(negedge clk_rx);
    reset_rx = 1'b0;
    m_id   = 8'h00;
    m_data = 16'h0000;
    m_cfg  = 1'b0;
    @(negedge clk_rx);
    send_short(4'h6, 8'hC3, 1'b0);
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk_rx);
    repeat (3) @(negedge clk_rx);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL midreset_drain: got %0d pending, required 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
`ifdef SENT_SERIAL_CRC_EN
    crc_on = 1'b1;
`else
    crc_on = 1'b0;
`endif
    test_reset();
    test_short();
    test_enhanced();
    test_crc_error();
    test_frame_error();
    test_restart();
    test_back_to_back();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
